// File: rtl/nonrestoring_divider_pkg.sv
// Shared arithmetic definitions: default datapath width and sequencer state encoding.
// Also used by the Booth multiplier.
package nonrestoring_divider_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StIter = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } arith_state_e;

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Load/done handshake and operand/result bundle for the sequential divider.
interface nonrestoring_divider_if
    import nonrestoring_divider_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
);

    logic         load;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output load, A, B,
        input  done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  load, A, B,
        output done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_addsub.sv
// (N+1)-bit partial-remainder adder/subtractor: subtracts the divisor when sub is set,
// otherwise adds it. Shared by the iteration step and the final remainder restore.
module div_addsub
    import nonrestoring_divider_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input  logic [N:0]   operand,
    input  logic [N-1:0] divisor,
    input  logic         sub,
    output logic [N:0]   result
);

    always_comb begin
        result = sub ? (operand - {1'b0, divisor}) : (operand + {1'b0, divisor});
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider: non-restoring division on operand magnitudes, one quotient
// bit per cycle, with sign correction and remainder restore in a final FIX cycle.
module nonrestoring_divider
    import nonrestoring_divider_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) (
    input logic                    clk,
    input logic                    rst_n,
    nonrestoring_divider_if.slave  bus
);

    localparam int unsigned CntW = $clog2(N);

    arith_state_e state_q, state_d;

    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    d_q, d_d;
    logic [N:0]      p_q, p_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [N-1:0]    quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            done_q, done_d;

    logic [N:0]      shift;
    logic [N:0]      addsub_operand;
    logic [N:0]      addsub_res;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [N-1:0]    rem_mag;
    logic            divisor_zero;

    // The P sign bit picks subtract/add in both ITER and FIX; in FIX the result is only
    // taken when P is negative, which makes it the restore add.
    always_comb begin
        shift          = {p_q[N-1:0], q_q[N-1]};
        addsub_operand = (state_q == StFix) ? p_q : shift;
    end

    div_addsub #(
        .N (N)
    ) u_addsub (
        .operand (addsub_operand),
        .divisor (d_q),
        .sub     (~p_q[N]),
        .result  (addsub_res)
    );

    always_comb begin
        a_mag        = sign_a_q ? (~a_q + 1'b1) : a_q;
        b_mag        = sign_b_q ? (~b_q + 1'b1) : b_q;
        rem_mag      = p_q[N] ? addsub_res[N-1:0] : p_q[N-1:0];
        divisor_zero = (d_q == '0);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        q_d      = q_q;
        d_d      = d_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        done_d   = done_q;

        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (bus.load) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    sign_a_d = bus.A[N-1];
                    sign_b_d = bus.B[N-1];
                    state_d  = StInit;
                end
            end
            StInit: begin
                q_d     = a_mag;
                d_d     = b_mag;
                p_d     = '0;
                cnt_d   = CntW'(N - 1);
                state_d = StIter;
            end
            StIter: begin
                p_d   = addsub_res;
                q_d   = {q_q[N-2:0], ~addsub_res[N]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                p_d    = p_q[N] ? addsub_res : p_q;
                // Dividing by zero leaves an all-ones magnitude, reported as -1 unnegated.
                quot_d = ((sign_a_q ^ sign_b_q) && !divisor_zero) ? (~q_q + 1'b1) : q_q;
                rem_d  = sign_a_q ? (~rem_mag + 1'b1) : rem_mag;
                dbz_d  = divisor_zero;
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            q_q      <= '0;
            d_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            q_q      <= q_d;
            d_q      <= d_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider at N=32: directed vectors, handshake,
// back-to-back and mid-operation reset.
module tb_nonrestoring_divider;

    localparam int unsigned N = 32;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        exp_t         e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    nonrestoring_divider_if #(.N(N)) bus ();

    nonrestoring_divider #(
        .N (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_fifo[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_done++;
            if (exp_fifo.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with no outstanding operation (t=%0t)",
                         $time);
            end else begin
                mon_e = exp_fifo.pop_front();
                check("quotient", bus.quotient, mon_e.q);
                check("remainder", bus.remainder, mon_e.r);
                check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, mon_e.dbz});
            end
        end
    end

    function automatic exp_t mk(input logic [N-1:0] q, input logic [N-1:0] r, input logic dbz);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        return e;
    endfunction

    // Returns at the negedge following the load edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e,
                         input bit expect_result);
        @(negedge clk);
        bus.load = 1'b1;
        bus.A    = a;
        bus.B    = b;
        if (expect_result) exp_fifo.push_back(e);
        @(negedge clk);
        bus.load = 1'b0;
        bus.A    = $urandom;
        bus.B    = $urandom;
    endtask

    // lat = number of edges after the reference edge at which done is first seen high.
    task automatic wait_done(input int start, output int lat);
        lat = -1;
        for (int k = start; k < start + 60; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    vec_t vecs[10];
    int   lat;
    int   done_before;

    initial begin
        vecs[0] = '{a: 32'd100,          b: 32'd7,          e: mk(32'd14, 32'd2, 1'b0)};
        vecs[1] = '{a: -32'sd100,        b: 32'd7,          e: mk(-32'sd14, -32'sd2, 1'b0)};
        vecs[2] = '{a: 32'd100,          b: -32'sd7,        e: mk(-32'sd14, 32'd2, 1'b0)};
        vecs[3] = '{a: -32'sd100,        b: -32'sd7,        e: mk(32'd14, -32'sd2, 1'b0)};
        vecs[4] = '{a: 32'h8000_0000,    b: 32'hFFFF_FFFF,  e: mk(32'h8000_0000, 32'd0, 1'b0)};
        vecs[5] = '{a: 32'h7FFF_FFFF,    b: 32'd1,          e: mk(32'h7FFF_FFFF, 32'd0, 1'b0)};
        vecs[6] = '{a: 32'd55,           b: 32'd0,          e: mk(32'hFFFF_FFFF, 32'd55, 1'b1)};
        vecs[7] = '{a: -32'sd55,         b: 32'd0,          e: mk(32'hFFFF_FFFF, -32'sd55, 1'b1)};
        vecs[8] = '{a: 32'd7,            b: 32'd100,        e: mk(32'd0, 32'd7, 1'b0)};
        vecs[9] = '{a: 32'h8000_0000,    b: 32'd2,          e: mk(32'hC000_0000, 32'd0, 1'b0)};

        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.A    = '0;
        bus.B    = '0;
        repeat (3) @(negedge clk);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_quotient", bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        check("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
            wait_done(1, lat);
            check("latency", lat, 32'd34);
            @(negedge clk);
            check("done_single_cycle", {31'd0, bus.done}, 32'd0);
            repeat (2) @(negedge clk);
        end

        // A second load during ITER must be ignored.
        done_before = n_done;
        issue(32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 1'b1);
        repeat (5) @(negedge clk);
        bus.load = 1'b1;
        bus.A    = -32'sd100;
        bus.B    = -32'sd7;
        @(negedge clk);
        bus.load = 1'b0;
        wait_done(7, lat);
        check("latency_ignored_load", lat, 32'd34);
        repeat (45) @(negedge clk);
        check("done_count_ignored_load", n_done - done_before, 32'd1);

        // load held high: results every N+4 cycles.
        @(negedge clk);
        bus.load = 1'b1;
        bus.A    = 32'd100;
        bus.B    = -32'sd7;
        exp_fifo.push_back(mk(-32'sd14, 32'd2, 1'b0));
        exp_fifo.push_back(mk(32'd14, -32'sd2, 1'b0));
        wait_done(0, lat);
        check("b2b_first_latency", lat, 32'd34);
        bus.A = -32'sd100;
        bus.B = -32'sd7;
        wait_done(1, lat);
        check("b2b_period", lat, 32'd36);
        bus.load = 1'b0;
        repeat (45) @(negedge clk);

        // Reset mid-iteration discards the operation.
        done_before = n_done;
        issue(32'd1000, 32'd3, mk(32'd0, 32'd0, 1'b0), 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_done", {31'd0, bus.done}, 32'd0);
        check("midreset_quotient", bus.quotient, 32'd0);
        check("midreset_remainder", bus.remainder, 32'd0);
        check("midreset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midreset_no_done", n_done - done_before, 32'd0);

        issue(32'd1000, 32'd3, mk(32'd333, 32'd1, 1'b0), 1'b1);
        wait_done(1, lat);
        check("post_reset_latency", lat, 32'd34);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", exp_fifo.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider.md
# nonrestoring_divider

Sequential signed integer divider: the inverse operation of the team's sequential Booth multiplier, with the same `load`/`done` handshake, parameterisation and iteration style. It computes an N-bit quotient and remainder from an N-bit dividend and an N-bit divisor. It uses non-restoring division on operand magnitudes, one quotient bit per cycle. It sits beside the multiplier in the arithmetic datapath and serves DIV/REM-type operations.

## Interface
- `N`, default 32: operand, quotient and remainder width in bits. Must be at least 4.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: start request. Sampled only in IDLE.
- `A`  in  N: signed dividend. Captured on the load edge.
- `B`  in  N: signed divisor. Captured on the load edge.
- `done`  out  1: one-cycle pulse; result valid. Reset value 0.
- `quotient`  out  N: signed quotient. Reset value 0.
- `remainder`  out  N: signed remainder. Reset value 0.
- `div_by_zero`  out  1: divisor was 0. Valid with `done`, held with the result. Reset value 0.

## Operation
- States: IDLE, INIT, ITER, FIX, DONE.
- IDLE:
  - `load`=1 → capture A, B and their sign bits; go to INIT.
  - Otherwise stay in IDLE.
  - Clear `done`.
- INIT:
  - Compute magnitudes |A| and |B| as N-bit unsigned. |−2^(N−1)| = 2^(N−1) fits.
  - Q register = |A|. Divisor register D = |B|.
  - P = 0, an (N+1)-bit signed partial remainder.
  - counter = N−1. Go to ITER.
- ITER, one cycle per quotient bit:
  - Shift: S = {P[N−1:0], Q[N−1]}.
  - If P ≥ 0: P ← S − D. Else: P ← S + D.
  - Q ← {Q[N−2:0], ~Pnew[N]}.
  - counter−1. When counter was 0, go to FIX.
- FIX:
  - If P < 0: P ← P + D. This is the remainder restore.
  - Sign fix on the same cycle:
    - Negate the quotient if signA ≠ signB.
    - Negate the remainder if signA = 1.
  - Go to DONE.
- DONE:
  - Register `quotient`, `remainder` and `div_by_zero`.
  - `done` ← 1. Go to IDLE.
- Arithmetic rules:
  - Truncation is toward zero.
  - The remainder takes the sign of the dividend.
  - Identity: A = quotient·B + remainder, evaluated mod 2^N.
- Divide by zero (B = 0):
  - Full normal latency.
  - `quotient` = all ones (−1), `remainder` = A, `div_by_zero` = 1.
- Overflow (A = −2^(N−1), B = −1):
  - `quotient` = −2^(N−1), `remainder` = 0, `div_by_zero` = 0.
  - This result comes out of the datapath naturally; there is no special case.
- Outputs hold their last result until the next DONE. They are not cleared in IDLE.

## Timing
- Edge numbering:
  - Edge 0: `load` sampled high in IDLE.
  - Edges 1 to N: ITER cycles, where edge 1 leaves INIT.
  - Edge N+1: FIX.
  - Edge N+2: DONE registers the result.
- `done` is high for exactly the cycle after edge N+2 and is cleared at edge N+3.
- Total latency: N+2 cycles from the load edge to the `done` edge. This is 34 for N=32.
- `load` is ignored in every state except IDLE; it is neither queued nor restarted.
- `load` held high continuously: a new operation starts in the first IDLE cycle after DONE. The back-to-back period is N+4 cycles.
- `rst_n` low at any time, including mid-iteration:
  - State goes to IDLE immediately.
  - All outputs and internal registers go to 0.
  - The in-flight operation is discarded and produces no `done`.
- A and B may change freely after the load edge.

## Structure
- Shared arithmetic package holds:
  - State encoding constants: 3-bit, IDLE=0, INIT=1, ITER=2, FIX=3, DONE=4.
  - The default width constant.
  - The package is shared with the Booth multiplier.
- One sub-module, `div_addsub`:
  - (N+1)-bit add/subtract selected by the P sign bit.
  - Used by both ITER and the FIX restore.
- FSM, counter and sign logic stay in the top module.

## Test plan
- N=32:
  - 100 / 7 → quotient 14, remainder 2.
  - `done` asserts exactly 34 cycles after the load edge.
- Signs:
  - −100 / 7 → −14, −2.
  - 100 / −7 → −14, 2.
  - −100 / −7 → 14, −2.
- Boundaries:
  - 0x80000000 / −1 → quotient 0x80000000, remainder 0, `div_by_zero` 0.
  - 0x7FFFFFFF / 1 → 0x7FFFFFFF, 0.
- Divide by zero:
  - 55 / 0 → quotient 0xFFFFFFFF, remainder 55, `div_by_zero` 1.
  - −55 / 0 → quotient 0xFFFFFFFF, remainder −55.
- Handshake:
  - Pulse `load` again during ITER with different operands → ignored; first result only, single `done`.
  - `load` held high → back-to-back results every 36 cycles.
- Reset:
  - Assert `rst_n` low at ITER cycle 10 → all outputs 0 and no `done`.
  - A new `load` after release then produces the correct result.
